sobol_rng: RTL
==============

// Module: sobol_rng
// PURPOSE
//   Stateful Sobol-sequence random number source for the stochastic-computing datapath.
//   Holds an index counter and computes the index of its least-significant zero (LSZ) each cycle.
//   On each advance it XORs the direction vector selected by that index into the output register.
//   Output is a full-period, low-discrepancy stream for the SC comparators downstream.
// PARAMETERS
//   BITWIDTH     4                    width of counter, direction vectors and random output; legal 2..16
//   LOGBITWIDTH  $clog2(BITWIDTH)     width of LSZ index output
//   DIM          0                    direction-vector set: 0 = van der Corput, 1 = Sobol dimension 2
// PORTS
//   iClk      in   1             clock, all state on rising edge
//   iRstN     in   1             asynchronous active-low reset
//   iEn       in   1             advance sequence by one step this cycle
//   iClr      in   1             synchronous restart of sequence; priority over iEn
//   oRand     out  BITWIDTH      registered random value of current step
//   oCnt      out  BITWIDTH      registered step index (counter)
//   oLszIdx   out  LOGBITWIDTH   combinational LSZ index of oCnt; 0 when oCnt is all ones
//   oWrap     out  1             registered 1-cycle pulse: previous cycle completed a full period
// BEHAVIOUR
//   - Reset (iRstN=0, async): oCnt=0, oRand=0, oWrap=0. Outputs hold these values until the first advance.
//   - Direction vectors V[k], k=0..BITWIDTH-1. Built at elaboration; no runtime storage.
//       V[0] = 1<<(BITWIDTH-1).
//       DIM=0: V[k] = 1<<(BITWIDTH-1-k).
//       DIM=1: V[k] = V[k-1] ^ (V[k-1]>>1).
//   - LSZ: index of lowest 0 bit of oCnt.
//       Thermometer/one-hot priority scan over ~oCnt, same encoding as the lsz stage.
//       oCnt all ones -> oLszIdx=0, with no valid zero.
//   - Per rising edge, evaluated in priority order:
//       1. iClr=1: oCnt<=0, oRand<=0, oWrap<=0. iEn is ignored.
//       2. iEn=1, oCnt != all ones: oRand<=oRand^V[oLszIdx]; oCnt<=oCnt+1; oWrap<=0.
//       3. iEn=1, oCnt == all ones (wrap step): oRand<=0; oCnt<=0; oWrap<=1.
//       4. otherwise: hold oCnt and oRand; oWrap<=0.
//   - Latency: the new oRand is visible the cycle after iEn is sampled.
//       oRand at step 0 is 0, i.e. sequence value for index 0.
//   - Period is exactly 2^BITWIDTH advances. For DIM=0, every BITWIDTH-bit value appears exactly once per period.
//   - iEn may toggle freely. Stall cycles neither skip nor repeat steps.
//   - Reset asserted mid-period aborts immediately. After release the sequence restarts from step 0.
//   - No arithmetic overflow: oCnt wraps only via rule 3, and the XOR path is width-preserving.
// TESTING
//   1. Reset, then BITWIDTH=4, DIM=0, iEn=1 for 16 cycles.
//      -> oRand = 0,8,12,4,6,14,10,2,3,11,15,7,5,13,9,1, then 0 with oWrap=1 for one cycle.
//   2. BITWIDTH=4, DIM=1, iEn=1 for 4 cycles from reset.
//      -> oRand = 0,8,4,12,6; oLszIdx = 0,1,0,2,0.
//   3. DIM=0, iEn toggled 1,0,0,1,0,1.
//      -> oRand = 0,8,8,8,12,12,4; oCnt holds during stalls.
//   4. Run to oCnt=5, then assert iClr and iEn together.
//      -> next cycle oCnt=0, oRand=0, oWrap=0; sequence resumes at 8.
//   5. Drop iRstN asynchronously mid-cycle at oCnt=9.
//      -> outputs zero before the next edge; after release with iEn=1, oRand=8.
//   6. BITWIDTH=8, DIM=0, 256 advances.
//      -> all 256 values seen once; oWrap pulses exactly once, on the cycle oRand returns to 0.

Source files
------------

// File: rtl/sobol_rng_if.sv
// Control and observation signals of the Sobol sequence source.
// The enable and clear inputs are driven by the master; the registered results are driven by the slave.
interface sobol_rng_if #(
    parameter int BITWIDTH    = 4,
    parameter int LOGBITWIDTH = $clog2(BITWIDTH)
);
    logic                   iEn;
    logic                   iClr;
    logic [BITWIDTH-1:0]    oRand;
    logic [BITWIDTH-1:0]    oCnt;
    logic [LOGBITWIDTH-1:0] oLszIdx;
    logic                   oWrap;

    modport master (
        output iEn, iClr,
        input  oRand, oCnt, oLszIdx, oWrap
    );

    modport slave (
        input  iEn, iClr,
        output oRand, oCnt, oLszIdx, oWrap
    );
endinterface

// File: rtl/sobol_rng.sv
// Sobol / van der Corput sequence source. Each advance XORs the direction vector chosen by the
// least-significant zero of the step counter into the output, giving a full-period low-discrepancy stream.
module sobol_rng #(
    parameter int BITWIDTH    = 4,
    parameter int LOGBITWIDTH = $clog2(BITWIDTH),
    parameter int DIM         = 0
) (
    input  logic        iClk,
    input  logic        iRstN,
    sobol_rng_if.slave  bus
);
    logic [BITWIDTH-1:0]    cnt_q, cnt_d;
    logic [BITWIDTH-1:0]    rand_q, rand_d;
    logic                   wrap_q, wrap_d;

    logic [BITWIDTH-1:0]    dir_vec [BITWIDTH];
    logic [BITWIDTH-1:0]    lsz_onehot;
    logic [BITWIDTH-1:0]    dir_sel;
    logic [LOGBITWIDTH-1:0] lsz_idx;
    logic                   cnt_full;

    // Direction vectors are pure constants; they fold away during synthesis.
    generate
        for (genvar gi = 0; gi < BITWIDTH; gi++) begin : g_dir
            if (gi == 0) begin : g_first
                assign dir_vec[gi] = BITWIDTH'(1) << (BITWIDTH - 1);
            end else if (DIM == 0) begin : g_vdc
                assign dir_vec[gi] = BITWIDTH'(1) << (BITWIDTH - 1 - gi);
            end else begin : g_sobol2
                assign dir_vec[gi] = dir_vec[gi-1] ^ (dir_vec[gi-1] >> 1);
            end
        end
    endgenerate

    // Adding one flips the trailing ones and the lowest zero; masking with ~cnt isolates that zero.
    assign lsz_onehot = ~cnt_q & (cnt_q + BITWIDTH'(1));
    assign cnt_full   = &cnt_q;

    always_comb begin
        dir_sel = '0;
        lsz_idx = '0;
        for (int k = 0; k < BITWIDTH; k++) begin
            if (lsz_onehot[k]) begin
                dir_sel = dir_sel | dir_vec[k];
                lsz_idx = lsz_idx | LOGBITWIDTH'(k);
            end
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        rand_d = rand_q;
        wrap_d = 1'b0;
        if (bus.iClr) begin
            cnt_d  = '0;
            rand_d = '0;
        end else if (bus.iEn) begin
            if (cnt_full) begin
                cnt_d  = '0;
                rand_d = '0;
                wrap_d = 1'b1;
            end else begin
                cnt_d  = cnt_q + BITWIDTH'(1);
                rand_d = rand_q ^ dir_sel;
            end
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            cnt_q  <= '0;
            rand_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            rand_q <= rand_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.oRand   = rand_q;
    assign bus.oCnt    = cnt_q;
    assign bus.oLszIdx = lsz_idx;
    assign bus.oWrap   = wrap_q;
endmodule
